// File: rtl/stap_responder.sv
// Secondary-side STAP responder: 1149.1 TAP controller with IR, IDCODE,
// BYPASS and a USER register that drives the die-local configuration bus.
module stap_responder #(
  parameter int                IR_W       = 4,
  parameter int                USER_W     = 8,
  parameter logic [31:0]       IDCODE_VAL = 32'h1000_0A8D,
  parameter logic [IR_W-1:0]   OPC_IDCODE = 4'b0010,
  parameter logic [IR_W-1:0]   OPC_USER   = 4'b1000,
  parameter logic [IR_W-1:0]   OPC_BYPASS = 4'b1111
) (
  input  logic              STCK,
  input  logic              SRST,
  input  logic              STMS,
  input  logic              STDI,
  output logic              STDO,
  output logic              STDO_EN,
  output logic [USER_W-1:0] USER_REG,
  output logic [3:0]        TAP_STATE
);

  typedef enum logic [3:0] {
    TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
    SH_DR  = 4'h4, EX1_DR = 4'h5, PAU_DR = 4'h6, EX2_DR = 4'h7,
    UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
    EX1_IR = 4'hC, PAU_IR = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {SEL_ID, SEL_USER, SEL_BYP} dr_sel_t;

  tap_state_t        state, nxt;
  dr_sel_t           sel;
  logic [IR_W-1:0]   ir, ir_sr;
  logic [31:0]       id_sr;
  logic [USER_W-1:0] user_sr;
  logic              byp_sr;

  assign TAP_STATE = state;

  always_comb begin
    nxt = state;
    unique case (state)
      TLR:            nxt = STMS ? TLR    : RTI;
      RTI:            nxt = STMS ? SEL_DR : RTI;
      SEL_DR:         nxt = STMS ? SEL_IR : CAP_DR;
      CAP_DR, SH_DR:  nxt = STMS ? EX1_DR : SH_DR;
      EX1_DR:         nxt = STMS ? UPD_DR : PAU_DR;
      PAU_DR:         nxt = STMS ? EX2_DR : PAU_DR;
      EX2_DR:         nxt = STMS ? UPD_DR : SH_DR;
      UPD_DR, UPD_IR: nxt = STMS ? SEL_DR : RTI;
      SEL_IR:         nxt = STMS ? TLR    : CAP_IR;
      CAP_IR, SH_IR:  nxt = STMS ? EX1_IR : SH_IR;
      EX1_IR:         nxt = STMS ? UPD_IR : PAU_IR;
      PAU_IR:         nxt = STMS ? EX2_IR : PAU_IR;
      EX2_IR:         nxt = STMS ? UPD_IR : SH_IR;
      default:        nxt = TLR;
    endcase
  end

  // Undefined opcodes fall through to the 1-bit bypass register.
  always_comb begin
    sel = SEL_BYP;
    case (ir)
      OPC_IDCODE: sel = SEL_ID;
      OPC_USER:   sel = SEL_USER;
      OPC_BYPASS: sel = SEL_BYP;
      default:    sel = SEL_BYP;
    endcase
  end

  always_ff @(posedge STCK or posedge SRST) begin
    if (SRST) begin
      state    <= TLR;
      ir       <= OPC_IDCODE;
      ir_sr    <= '0;
      id_sr    <= '0;
      user_sr  <= '0;
      byp_sr   <= 1'b0;
      USER_REG <= '0;
      STDO     <= 1'b0;
      STDO_EN  <= 1'b0;
    end else begin
      state   <= nxt;
      STDO    <= 1'b0;
      STDO_EN <= 1'b0;
      case (state)
        CAP_IR: ir_sr <= IR_W'(4'b0101);
        SH_IR: begin
          STDO    <= ir_sr[0];
          STDO_EN <= 1'b1;
          ir_sr   <= {STDI, ir_sr[IR_W-1:1]};
        end
        UPD_IR: ir <= ir_sr;
        CAP_DR: begin
          case (sel)
            SEL_ID:   id_sr   <= IDCODE_VAL;
            SEL_USER: user_sr <= USER_REG;
            default:  byp_sr  <= 1'b0;
          endcase
        end
        SH_DR: begin
          STDO_EN <= 1'b1;
          case (sel)
            SEL_ID: begin
              STDO  <= id_sr[0];
              id_sr <= {STDI, id_sr[31:1]};
            end
            SEL_USER: begin
              STDO    <= user_sr[0];
              user_sr <= {STDI, user_sr[USER_W-1:1]};
            end
            default: begin
              STDO   <= byp_sr;
              byp_sr <= STDI;
            end
          endcase
        end
        UPD_DR: if (sel == SEL_USER) USER_REG <= user_sr;
        default: ;
      endcase
      // Any path into TLR reselects IDCODE; UPD_IR can never lead there.
      if (nxt == TLR) ir <= OPC_IDCODE;
    end
  end

endmodule

// File: tb/tb_stap_responder.sv
// Scoreboard bench for stap_responder: a per-edge reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_stap_responder;

  logic       STCK = 1'b0;
  logic       SRST = 1'b0;
  logic       STMS = 1'b1;
  logic       STDI = 1'b0;
  logic       STDO, STDO_EN;
  logic [7:0] USER_REG;
  logic [3:0] TAP_STATE;

  stap_responder #(.IR_W(4), .USER_W(8)) dut (
    .STCK(STCK), .SRST(SRST), .STMS(STMS), .STDI(STDI),
    .STDO(STDO), .STDO_EN(STDO_EN), .USER_REG(USER_REG), .TAP_STATE(TAP_STATE)
  );

  always #5 STCK = ~STCK;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] user;
    logic       stdo;
    logic       en;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   last_so;

  // Next-state tables indexed by state number, for STMS=0 and STMS=1.
  int ns0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int ns1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_st;
  logic [3:0]  m_ir, m_irsr;
  logic [31:0] m_dr;
  int          m_w;
  logic [7:0]  m_user;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_ir = 4'b0010; m_irsr = '0; m_dr = '0; m_w = 1; m_user = '0;
  endfunction

  // One abstract data register of width m_w stands in for whichever DR is selected.
  function automatic void model(bit tms, bit tdi);
    exp_t e;
    e = '0;
    case (m_st)
      10: m_irsr = 4'b0101;
      11: begin
        e.stdo = m_irsr[0]; e.en = 1'b1;
        m_irsr = {tdi, m_irsr[3:1]};
      end
      15: m_ir = m_irsr;
      3: begin
        if (m_ir == 4'b0010)      begin m_dr = 32'h1000_0A8D; m_w = 32; end
        else if (m_ir == 4'b1000) begin m_dr = {24'h0, m_user}; m_w = 8; end
        else                      begin m_dr = '0; m_w = 1; end
      end
      4: begin
        e.stdo = m_dr[0]; e.en = 1'b1;
        m_dr = m_dr >> 1;
        m_dr[m_w-1] = tdi;
      end
      8: if (m_ir == 4'b1000) m_user = m_dr[7:0];
      default: ;
    endcase
    m_st = tms ? ns1[m_st] : ns0[m_st];
    if (m_st == 0) m_ir = 4'b0010;
    e.st = 4'(m_st); e.user = m_user;
    sbq.push_back(e);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge STCK);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("scoreboard{state,user,stdo,en}", 32'({TAP_STATE, USER_REG, STDO, STDO_EN}), 32'(e));
      end
    end
  end

  task automatic step(input bit tms, input bit tdi);
    STMS = tms; STDI = tdi;
    @(posedge STCK);
    model(tms, tdi);
    @(negedge STCK);
    last_so = STDO;
  endtask

  task automatic async_reset();
    #2 SRST = 1'b1;
    #1;
    chk("rst_stdo", 32'(STDO), 32'h0);
    chk("rst_stdo_en", 32'(STDO_EN), 32'h0);
    chk("rst_user_reg", 32'(USER_REG), 32'h0);
    chk("rst_tap_state", 32'(TAP_STATE), 32'h0);
    model_reset();
    sbq.delete();
    @(posedge STCK);
    @(negedge STCK);
    SRST = 1'b0;
  endtask

  task automatic to_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1, 0); step(0, 0);
  endtask

  // From RTI; optional pause after pause_at bits; returns STDO bits LSB-first.
  task automatic scan_dr(input logic [63:0] v, input int n, input int pause_at,
                         output logic [63:0] got);
    got = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      bit brk;
      brk = (i == n - 1) || (pause_at > 0 && i == pause_at - 1);
      step(brk, v[i]);
      got[i] = last_so;
      if (brk && i != n - 1) begin
        step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      end
    end
    step(1, 0); step(0, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] got;
    logic [31:0] idbits;
    logic [3:0]  irbits;
    int          en_cnt;
    model_reset();
    @(negedge STCK);
    async_reset();

    // IDCODE read straight out of reset.
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    en_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      if (i < 32) begin
        step(i == 31, 1'($urandom));
        idbits[i] = last_so;
      end else begin
        step(i == 32, 0);
      end
      if (STDO_EN) en_cnt++;
    end
    chk("idcode_stream", idbits, 32'h1000_0A8D);
    chk("idcode_en_count", 32'(en_cnt), 32'd32);

    // Five STMS=1 edges from PauDR.
    step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(1, 0); step(0, 0); step(0, 0);
    repeat (5) step(1, 0);
    chk("tlr_recovery_state", 32'(TAP_STATE), 32'h0);
    step(0, 0);
    scan_dr(64'h0, 32, 0, got);
    chk("tlr_recovery_idcode", got[31:0], 32'h1000_0A8D);

    // IR capture pattern.
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 0);
      irbits[i] = last_so;
    end
    step(1, 0); step(0, 0);
    chk("ir_capture", 32'(irbits), 32'h5);

    // Bypass delay: STDI 1,0,1,1 -> STDO 0,1,0,1.
    load_ir(4'b1111);
    scan_dr(64'b1101, 4, 0, got);
    chk("bypass_delay", got[31:0], 32'hA);

    // USER write, readback, clear.
    load_ir(4'b1000);
    scan_dr(64'hA5, 8, 0, got);
    chk("user_write_a5", 32'(USER_REG), 32'hA5);
    scan_dr(64'h00, 8, 0, got);
    chk("user_readback", got[31:0], 32'hA5);
    chk("user_clear", 32'(USER_REG), 32'h0);

    // Pause mid-scan and resume through Ex2.
    scan_dr(64'h3C, 8, 3, got);
    chk("user_pause_resume", 32'(USER_REG), 32'h3C);

    // Undefined opcode acts as bypass and leaves USER_REG alone.
    load_ir(4'b0110);
    scan_dr(64'b0111, 4, 0, got);
    chk("undef_bypass", got[31:0], 32'hE);
    chk("undef_user_kept", 32'(USER_REG), 32'h3C);

    // Reset during a USER shift.
    load_ir(4'b1000);
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 0); step(0, 1);
    async_reset();
    step(0, 0);

    // Randomized scans.
    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      int n, p;
      case ($urandom_range(0, 3))
        0: op = 4'b0010;
        1: op = 4'b1000;
        2: op = 4'b1111;
        default: op = 4'($urandom);
      endcase
      load_ir(op);
      n = $urandom_range(1, 40);
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      scan_dr({$urandom, $urandom}, n, p, got);
      repeat ($urandom_range(0, 12)) step($urandom_range(0, 3) == 0, 1'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        async_reset();
        step(0, 0);
      end else begin
        to_rti();
      end
    end

    repeat (2) @(negedge STCK);
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
